// File: rtl/in_wrapper_pack.sv
// Input wrapper for the IMC: packs NUM_WORDS handshaked DATA_W-bit words into one operand and issues a start pulse.
// Define IN_WRAPPER_PINGPONG_EN for two alternating operand banks; the default build is single-bank.
module in_wrapper_pack #(
    parameter  int DATA_W    = 8,
    parameter  int NUM_WORDS = 4,
    localparam int CNT_W     = $clog2(NUM_WORDS + 1)
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic [DATA_W-1:0]           data_i,
    input  logic                        data_valid_i,
    output logic                        data_ready_o,
    input  logic                        flush_i,
    input  logic                        imc_ready_i,
    output logic                        imc_start_o,
    output logic [NUM_WORDS*DATA_W-1:0] imc_data_o,
    output logic [CNT_W-1:0]            fill_cnt_o
);

    localparam int OP_W = NUM_WORDS * DATA_W;
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_WORDS);

    typedef enum logic [1:0] {
        COLLECT  = 2'b00,
        WAIT_IMC = 2'b01,
        START    = 2'b10
    } state_t;

    state_t           state_r, state_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic             data_ready_s;
    logic             xfer_s;
    logic             wr_en_s;

    assign xfer_s       = data_valid_i && data_ready_s;
    assign data_ready_o = data_ready_s;
    assign imc_start_o  = (state_r == START);
    assign fill_cnt_o   = cnt_r;

`ifdef IN_WRAPPER_PINGPONG_EN

    // col_r: bank being filled; hb_r: bank owned by the handoff FSM (state_r)
    logic            col_r, col_n;
    logic            hb_r, hb_n;
    logic [1:0]      full_r, full_n;
    logic [OP_W-1:0] bank0_r, bank1_r;

    assign data_ready_s = !full_r[col_r];
    assign imc_data_o   = hb_r ? bank1_r : bank0_r;

    // Control state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= COLLECT;
            cnt_r   <= CNT_ZERO;
            col_r   <= 1'b0;
            hb_r    <= 1'b0;
            full_r  <= 2'b00;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            col_r   <= col_n;
            hb_r    <= hb_n;
            full_r  <= full_n;
        end
    end

    // Handoff sequencing, bank alternation and collecting-bank fill count
    always_comb begin
        state_n  = state_r;
        cnt_n    = cnt_r;
        col_n    = col_r;
        hb_n     = hb_r;
        full_n   = full_r;
        wr_en_s  = 1'b0;
        case (state_r)
            COLLECT:  state_n = COLLECT;
            WAIT_IMC: begin
                if (imc_ready_i) begin
                    state_n = START;
                end else begin
                    state_n = WAIT_IMC;
                end
            end
            START: begin
                full_n[hb_r] = 1'b0;
                state_n      = COLLECT;
            end
            default:  state_n = COLLECT;
        endcase

        // A full collecting bank waits here until the other bank is released
        if (full_r[col_r]) begin
            if (!full_n[~col_r]) begin
                col_n = ~col_r;
                cnt_n = CNT_ZERO;
            end else begin
                cnt_n = CNT_FULL;
            end
        end else if (flush_i) begin
            cnt_n = CNT_ZERO;
        end else if (xfer_s) begin
            wr_en_s = 1'b1;
            if (cnt_r == CNT_LAST) begin
                full_n[col_r] = 1'b1;
                if (!full_n[~col_r]) begin
                    col_n = ~col_r;
                    cnt_n = CNT_ZERO;
                end else begin
                    cnt_n = CNT_FULL;
                end
            end else begin
                cnt_n = cnt_r + CNT_ONE;
            end
        end else begin
            cnt_n = cnt_r;
        end

        // At most one bank can be full while the handoff is idle
        if (state_n == COLLECT) begin
            if (full_n[0]) begin
                state_n = WAIT_IMC;
                hb_n    = 1'b0;
            end else if (full_n[1]) begin
                state_n = WAIT_IMC;
                hb_n    = 1'b1;
            end else begin
                hb_n    = hb_r;
            end
        end else begin
            hb_n = hb_r;
        end
    end

    // Operand bank storage; unwritten slots keep old contents
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            bank0_r <= '0;
            bank1_r <= '0;
        end else begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                if (wr_en_s && (cnt_r == CNT_W'(k))) begin
                    if (col_r) begin
                        bank1_r[k*DATA_W +: DATA_W] <= data_i;
                    end else begin
                        bank0_r[k*DATA_W +: DATA_W] <= data_i;
                    end
                end
            end
        end
    end

`else

    logic [OP_W-1:0] opnd_r;

    assign data_ready_s = (state_r == COLLECT);
    assign imc_data_o   = opnd_r;

    // Control state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= COLLECT;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
        end
    end

    // Collect/handoff sequencing; flush overrides everything including a transfer
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        wr_en_s = 1'b0;
        if (flush_i) begin
            state_n = COLLECT;
            cnt_n   = CNT_ZERO;
        end else begin
            case (state_r)
                COLLECT: begin
                    if (xfer_s) begin
                        wr_en_s = 1'b1;
                        if (cnt_r == CNT_LAST) begin
                            cnt_n   = CNT_FULL;
                            state_n = WAIT_IMC;
                        end else begin
                            cnt_n   = cnt_r + CNT_ONE;
                        end
                    end else begin
                        cnt_n = cnt_r;
                    end
                end
                WAIT_IMC: begin
                    if (imc_ready_i) begin
                        state_n = START;
                    end else begin
                        state_n = WAIT_IMC;
                    end
                end
                START: begin
                    state_n = COLLECT;
                    cnt_n   = CNT_ZERO;
                end
                default: begin
                    state_n = COLLECT;
                    cnt_n   = CNT_ZERO;
                end
            endcase
        end
    end

    // Operand storage; unwritten slots keep old contents
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            opnd_r <= '0;
        end else begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                if (wr_en_s && (cnt_r == CNT_W'(k))) begin
                    opnd_r[k*DATA_W +: DATA_W] <= data_i;
                end
            end
        end
    end

`endif

endmodule

// File: tb/tb_in_wrapper_pack.sv
// Directed self-checking bench for in_wrapper_pack: an 8x4 instance and a 4x6 instance.
module tb_in_wrapper_pack;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [7:0]  data;
    logic        valid;
    logic        ready;
    logic        flush;
    logic        imc_ready;
    logic        start;
    logic [31:0] idata;
    logic [2:0]  fill;

    logic [3:0]  data6;
    logic        valid6;
    logic        ready6;
    logic        flush6;
    logic        imc_ready6;
    logic        start6;
    logic [23:0] idata6;
    logic [2:0]  fill6;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk_i = ~clk_i;

    in_wrapper_pack #(.DATA_W(8), .NUM_WORDS(4)) u_dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .data_i(data), .data_valid_i(valid),
        .data_ready_o(ready), .flush_i(flush), .imc_ready_i(imc_ready),
        .imc_start_o(start), .imc_data_o(idata), .fill_cnt_o(fill)
    );

    in_wrapper_pack #(.DATA_W(4), .NUM_WORDS(6)) u_dut6 (
        .clk_i(clk_i), .rstn_i(rstn_i), .data_i(data6), .data_valid_i(valid6),
        .data_ready_o(ready6), .flush_i(flush6), .imc_ready_i(imc_ready6),
        .imc_start_o(start6), .imc_data_o(idata6), .fill_cnt_o(fill6)
    );

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic feed4(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            data  = w[k*8 +: 8];
            valid = 1'b1;
            step();
        end
        valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        chk_cnt++;
        if (ready !== 1'b1 || start !== 1'b0 || idata !== 32'h0 || fill !== 3'd0)
            $display("FAIL reset_values ready=%b start=%b data=%h fill=%0d exp 1/0/0/0", ready, start, idata, fill);
        else pass_cnt++;
        chk_cnt++;
        if (ready6 !== 1'b1 || start6 !== 1'b0 || idata6 !== 24'h0 || fill6 !== 3'd0)
            $display("FAIL reset_values6 ready=%b start=%b data=%h fill=%0d exp 1/0/0/0", ready6, start6, idata6, fill6);
        else pass_cnt++;
        step();
        rstn_i = 1'b1;
        step();
        chk_cnt++;
        if (ready !== 1'b1 || fill !== 3'd0)
            $display("FAIL post_reset_idle ready=%b fill=%0d exp 1/0", ready, fill);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        imc_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            data  = 8'(8'h11 * (k + 1));
            valid = 1'b1;
            step();
            chk_cnt++;
            if (fill !== 3'(k + 1)) $display("FAIL basic_fill act=%0d exp=%0d", fill, k + 1);
            else pass_cnt++;
        end
        valid = 1'b0;
        chk_cnt++;
        if (ready !== 1'b0 || start !== 1'b0 || idata !== 32'h44332211)
            $display("FAIL basic_wait ready=%b start=%b data=%h exp 0/0/44332211", ready, start, idata);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (start !== 1'b1 || idata !== 32'h44332211 || fill !== 3'd4)
            $display("FAIL basic_start start=%b data=%h fill=%0d exp 1/44332211/4", start, idata, fill);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (start !== 1'b0 || ready !== 1'b1 || fill !== 3'd0)
            $display("FAIL basic_after start=%b ready=%b fill=%0d exp 0/1/0", start, ready, fill);
        else pass_cnt++;
    endtask

    task automatic test_wait();
        imc_ready = 1'b0;
        feed4(32'h8D7C6B5A);
        data  = 8'hFF;
        valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk_cnt++;
            if (ready !== 1'b0 || start !== 1'b0 || idata !== 32'h8D7C6B5A || fill !== 3'd4)
                $display("FAIL wait_hold c=%0d ready=%b start=%b data=%h fill=%0d exp 0/0/8D7C6B5A/4", c, ready, start, idata, fill);
            else pass_cnt++;
        end
        valid     = 1'b0;
        imc_ready = 1'b1;
        step();
        chk_cnt++;
        if (start !== 1'b1 || idata !== 32'h8D7C6B5A)
            $display("FAIL wait_start start=%b data=%h exp 1/8D7C6B5A", start, idata);
        else pass_cnt++;
        imc_ready = 1'b0;
        step();
        chk_cnt++;
        if (start !== 1'b0 || ready !== 1'b1 || fill !== 3'd0)
            $display("FAIL wait_after start=%b ready=%b fill=%0d exp 0/1/0", start, ready, fill);
        else pass_cnt++;
    endtask

    task automatic test_valid_toggle();
        imc_ready6 = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            valid6 = (i % 2 == 0);
            data6  = (i % 2 == 0) ? 4'(i / 2 + 1) : 4'hF;
            step();
            chk_cnt++;
            if (fill6 !== 3'(i / 2 + 1)) $display("FAIL toggle_fill i=%0d act=%0d exp=%0d", i, fill6, i / 2 + 1);
            else pass_cnt++;
        end
        valid6 = 1'b0;
        chk_cnt++;
        if (idata6 !== 24'h654321 || start6 !== 1'b0)
            $display("FAIL toggle_data data=%h start=%b exp 654321/0", idata6, start6);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (start6 !== 1'b1 || idata6 !== 24'h654321)
            $display("FAIL toggle_start start=%b data=%h exp 1/654321", start6, idata6);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (start6 !== 1'b0 || ready6 !== 1'b1 || fill6 !== 3'd0)
            $display("FAIL toggle_after start=%b ready=%b fill=%0d exp 0/1/0", start6, ready6, fill6);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        int starts;
        imc_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            data  = 8'(k + 1);
            valid = 1'b1;
            step();
        end
        flush = 1'b1;
        data  = 8'hEE;
        valid = 1'b1;
        step();
        flush = 1'b0;
        valid = 1'b0;
        chk_cnt++;
        if (fill !== 3'd0 || ready !== 1'b1)
            $display("FAIL flush_drop fill=%0d ready=%b exp 0/1", fill, ready);
        else pass_cnt++;
        feed4(32'hA4A3A2A1);
        chk_cnt++;
        if (idata !== 32'hA4A3A2A1 || fill !== 3'd4)
            $display("FAIL flush_data data=%h fill=%0d exp A4A3A2A1/4", idata, fill);
        else pass_cnt++;
        starts = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (start === 1'b1) starts++;
        end
        chk_cnt++;
        if (starts != 1) $display("FAIL flush_one_start starts=%0d exp=1", starts);
        else pass_cnt++;
        // abandon a completed operand while waiting for the IMC
        imc_ready = 1'b0;
        feed4(32'hB4B3B2B1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk_cnt++;
        if (fill !== 3'd0 || ready !== 1'b1 || start !== 1'b0)
            $display("FAIL flush_wait fill=%0d ready=%b start=%b exp 0/1/0", fill, ready, start);
        else pass_cnt++;
        imc_ready = 1'b1;
        starts    = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (start === 1'b1) starts++;
        end
        chk_cnt++;
        if (starts != 0) $display("FAIL flush_wait_nostart starts=%0d exp=0", starts);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int starts;
        imc_ready = 1'b0;
        feed4(32'hC4C3C2C1);
        chk_cnt++;
        if (ready !== 1'b0 || idata !== 32'hC4C3C2C1)
            $display("FAIL rstmid_pre ready=%b data=%h exp 0/C4C3C2C1", ready, idata);
        else pass_cnt++;
        #2;
        rstn_i = 1'b0;
        #1;
        chk_cnt++;
        if (ready !== 1'b1 || start !== 1'b0 || idata !== 32'h0 || fill !== 3'd0)
            $display("FAIL rstmid_async ready=%b start=%b data=%h fill=%0d exp 1/0/0/0", ready, start, idata, fill);
        else pass_cnt++;
        imc_ready = 1'b1;
        step();
        step();
        rstn_i = 1'b1;
        starts = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (start === 1'b1) starts++;
        end
        chk_cnt++;
        if (starts != 0 || fill !== 3'd0)
            $display("FAIL rstmid_nostart starts=%0d fill=%0d exp 0/0", starts, fill);
        else pass_cnt++;
    endtask

    task automatic test_pingpong();
        logic [31:0] exp_op [3];
        int   w;
        int   starts;
        int   last;
        logic rdy;
        exp_op[0] = 32'h04030201;
        exp_op[1] = 32'h08070605;
        exp_op[2] = 32'h0C0B0A09;
        imc_ready = 1'b1;
        w      = 0;
        starts = 0;
        last   = 0;
        for (int c = 0; c < 30; c++) begin
            rdy = ready;
            if (w < 12) begin
                chk_cnt++;
                if (rdy !== 1'b1) $display("FAIL pp_ready c=%0d act=%b exp=1", c, rdy);
                else pass_cnt++;
                data  = 8'(w + 1);
                valid = 1'b1;
            end else begin
                valid = 1'b0;
            end
            step();
            if (valid && rdy === 1'b1) w++;
            if (start === 1'b1) begin
                chk_cnt++;
                if (starts > 2 || idata !== exp_op[starts > 2 ? 2 : starts])
                    $display("FAIL pp_data n=%0d act=%h exp=%h", starts, idata, exp_op[starts > 2 ? 2 : starts]);
                else pass_cnt++;
                if (starts > 0) begin
                    chk_cnt++;
                    if (c - last != 4) $display("FAIL pp_spacing act=%0d exp=4", c - last);
                    else pass_cnt++;
                end
                last = c;
                starts++;
            end
        end
        valid = 1'b0;
        chk_cnt++;
        if (starts != 3) $display("FAIL pp_count act=%0d exp=3", starts);
        else pass_cnt++;
    endtask

    initial begin
        rstn_i     = 1'b0;
        data       = 8'h00;
        valid      = 1'b0;
        flush      = 1'b0;
        imc_ready  = 1'b0;
        data6      = 4'h0;
        valid6     = 1'b0;
        flush6     = 1'b0;
        imc_ready6 = 1'b0;
        test_reset();
`ifdef IN_WRAPPER_PINGPONG_EN
        test_pingpong();
`else
        test_basic();
        test_wait();
        test_valid_toggle();
        test_flush();
        test_reset_mid();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
